multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM: sequences the shared ALU, register file, unified memory and PC
//  across IF/ID/EX/MEM/WB steps instead of single-cycle decode. Takes opcode/func from the IR,
//  ALU zero and memory ready; drives all datapath enables, muxes and ALUop per step.
//  Sits between the IR and the multi-cycle datapath in the CPU top level.
// PARAMETERS
//  MEM_WAIT_EN  1  1: IF/MEM_RD/MEM_WR hold until mem_rdy=1; 0: mem_rdy ignored (treated as 1)
//  STATE_W      4  width of state output/encoding
// PORTS
//  clk       in   1        system clock, rising edge
//  rst_n     in   1        reset, asynchronous, active-low
//  op        in   6        IR[31:26]
//  func      in   6        IR[5:0]
//  zero      in   1        ALU zero flag (valid in EXE_BR)
//  mem_rdy   in   1        memory completes access this cycle
//  pcwr      out  1        PC load enable
//  pcsrc     out  2        00 PC+4, 01 branch target, 10 jump target
//  irwr      out  1        IR load enable
//  memrd     out  1        memory read strobe
//  memwr     out  1        memory write strobe
//  regdst    out  1        1: rd, 0: rt
//  ALUsrc    out  1        1: extended imm, 0: rt data
//  memtoreg  out  1        1: write-back from MDR
//  regwr     out  1        register file write enable
//  extop     out  1        1: sign-extend imm16, 0: zero-extend
//  ALUop     out  3        000 ADD 001 SUB 010 OR 011 AND 100 SLT
//  illegal   out  1        unsupported op/func, one-cycle pulse in ID
//  state     out  STATE_W  current state (debug)
// BEHAVIOUR
//  - rst_n=0: state<=S_IF asynchronously; all outputs forced 0 while low. First cycle after release is S_IF.
//  - Outputs are Moore-decoded from state; only exceptions: pcwr in EXE_BR (=zero), gated pcwr/irwr by mem_rdy.
//  - Unasserted outputs are 0 in every state.
//  - S_IF: memrd=1, ALUop=ADD; when mem_rdy: irwr=1, pcwr=1, pcsrc=00, ->S_ID; else hold.
//  - S_ID: decode op. R-type(000000)->EXE_R; addiu(001001)/ori(001101)->EXE_I;
//    lw(100011)/sw(101011)->EXE_MA; beq(000100)->EXE_BR; j(000010): pcwr=1,pcsrc=10, ->IF.
//    Unknown op, or R-type with func not in {100001,100011,100100,100101,101010}: illegal=1, ->IF, no writes.
//  - S_EXE_R: ALUsrc=0, ALUop from func (addu ADD, subu SUB, and AND, or OR, slt SLT) ->WB_R.
//  - S_WB_R: regdst=1, regwr=1, ALUop held as EXE_R ->IF.
//  - S_EXE_I: ALUsrc=1; addiu extop=1 ALUop=ADD; ori extop=0 ALUop=OR ->WB_I.
//  - S_WB_I: regdst=0, regwr=1, ALUsrc/extop/ALUop held ->IF.
//  - S_EXE_MA: ALUsrc=1, extop=1, ALUop=ADD; lw->MEM_RD, sw->MEM_WR.
//  - S_MEM_RD: memrd=1; hold until mem_rdy, then ->WB_MEM.  S_WB_MEM: memtoreg=1, regwr=1, regdst=0 ->IF.
//  - S_MEM_WR: memwr=1 held until mem_rdy, then ->IF.
//  - S_EXE_BR: ALUsrc=0, ALUop=SUB, extop=1, pcsrc=01, pcwr=zero ->IF.
//  - Latency (mem_rdy=1): j 2, beq 3, R/I/sw 4, lw 5 cycles; each mem_rdy=0 cycle adds one.
//  - op/func sampled only in ID/EX/WB from stable IR; IR changes only on irwr.
//  - Unused state encodings -> S_IF next cycle, outputs 0.
//  - rst_n low mid-access: memwr/regwr drop immediately; no partial write continues.
// STRUCTURE
//  - Package mc_ctrl_pkg: opcode/func localparams, ALUop codes, state encodings (S_IF..S_MEM_WR), pcsrc codes.
//  - One sub-module: mc_alu_dec (op,func -> ALUop, extop, func_ok), combinational, reused by EXE/WB states.
//  - Top holds state register, next-state logic, Moore output decode.
// TESTING
//  1. rst_n low during S_ID of addu -> all outputs 0 same cycle; after release state=S_IF, memrd=1.
//  2. op=000000 func=100001, mem_rdy=1 -> IF,ID,EXE_R,WB_R; regwr=1,regdst=1,ALUop=000 only in WB_R.
//  3. lw op=100011, mem_rdy=0 for 3 cycles in MEM_RD -> memrd held, state holds, regwr=1 memtoreg=1 in WB_MEM; 8 cycles total.
//  4. beq op=000100: zero=1 -> pcwr=1 pcsrc=01 ALUop=001 in EXE_BR; zero=0 -> pcwr=0; both 3 cycles.
//  5. j op=000010 -> ID asserts pcwr=1 pcsrc=10, next state S_IF; ori op=001101 -> extop=0 ALUop=010 in EXE_I/WB_I.
//  6. op=111111 and R-type func=000000 -> illegal=1 for exactly one cycle in ID; regwr=memwr=0; back to S_IF.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM:
// opcodes, R-type funcs, ALU operations, PC sources and states.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_R  = 4'd2,
    S_WB_R   = 4'd3,
    S_EXE_I  = 4'd4,
    S_WB_I   = 4'd5,
    S_EXE_MA = 4'd6,
    S_MEM_RD = 4'd7,
    S_WB_MEM = 4'd8,
    S_MEM_WR = 4'd9,
    S_EXE_BR = 4'd10
  } state_t;

  function automatic logic op_known(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_ADDIU, OP_ORI, OP_LW,
                      OP_SW, OP_BEQ, OP_J};
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU operation / immediate-extension decode from op and func.
// Shared by every EXE and WB state so the ALU setup stays stable.
module mc_alu_dec (
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic [2:0] aluop,
  output logic       extop,
  output logic       func_ok
);
  import mc_ctrl_pkg::*;

  // op/func to ALU operation, extension mode and R-type legality
  always_comb begin
    aluop   = ALU_ADD;
    extop   = 1'b0;
    func_ok = 1'b0;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        func_ok = 1'b1;
        unique case (func)
          FN_ADDU: aluop = ALU_ADD;
          FN_SUBU: aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLT:  aluop = ALU_SLT;
          default: func_ok = 1'b0;
        endcase
      end
      (op == OP_ORI): aluop = ALU_OR;
      (op == OP_BEQ): begin
        aluop = ALU_SUB;
        extop = 1'b1;
      end
      (op == OP_ADDIU || op == OP_LW || op == OP_SW):
        extop = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: steps the shared datapath
// through IF/ID/EX/MEM/WB and drives its enables and muxes.
module multicycle_ctrl #(
  parameter bit MEM_WAIT_EN = 1'b1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         op,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_rdy,
  output logic               pcwr,
  output logic [1:0]         pcsrc,
  output logic               irwr,
  output logic               memrd,
  output logic               memwr,
  output logic               regdst,
  output logic               ALUsrc,
  output logic               memtoreg,
  output logic               regwr,
  output logic               extop,
  output logic [2:0]         ALUop,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);
  import mc_ctrl_pkg::*;

  state_t     st;
  logic       rdy;
  logic       op_ok;
  logic       func_ok;
  logic       dec_extop;
  logic [2:0] dec_aluop;

  assign rdy   = MEM_WAIT_EN ? mem_rdy : 1'b1;
  assign state = STATE_W'(st);

  mc_alu_dec u_dec (
    .op      (op),
    .func    (func),
    .aluop   (dec_aluop),
    .extop   (dec_extop),
    .func_ok (func_ok)
  );

  assign op_ok = op_known(op) &&
                 (op != OP_RTYPE || func_ok);

  // state register and next-state sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_IF;
    end else begin
      case (st)
        S_IF:     if (rdy) st <= S_ID;
        S_ID: begin
          if (!op_ok) begin
            st <= S_IF;
          end else begin
            unique case (1'b1)
              (op == OP_RTYPE):
                st <= S_EXE_R;
              (op == OP_ADDIU || op == OP_ORI):
                st <= S_EXE_I;
              (op == OP_LW || op == OP_SW):
                st <= S_EXE_MA;
              (op == OP_BEQ):
                st <= S_EXE_BR;
              default:
                st <= S_IF;
            endcase
          end
        end
        S_EXE_R:  st <= S_WB_R;
        S_WB_R:   st <= S_IF;
        S_EXE_I:  st <= S_WB_I;
        S_WB_I:   st <= S_IF;
        S_EXE_MA: st <= (op == OP_LW) ? S_MEM_RD
                                      : S_MEM_WR;
        S_MEM_RD: if (rdy) st <= S_WB_MEM;
        S_WB_MEM: st <= S_IF;
        S_MEM_WR: if (rdy) st <= S_IF;
        S_EXE_BR: st <= S_IF;
        default:  st <= S_IF;
      endcase
    end
  end

  // state-decoded controls; reset low blanks everything at once
  always_comb begin
    pcwr     = 1'b0;
    pcsrc    = PC_SEQ;
    irwr     = 1'b0;
    memrd    = 1'b0;
    memwr    = 1'b0;
    regdst   = 1'b0;
    ALUsrc   = 1'b0;
    memtoreg = 1'b0;
    regwr    = 1'b0;
    extop    = 1'b0;
    ALUop    = ALU_ADD;
    illegal  = 1'b0;
    if (rst_n) begin
      case (st)
        S_IF: begin
          memrd = 1'b1;
          irwr  = rdy;
          pcwr  = rdy;
        end
        S_ID: begin
          if (!op_ok) begin
            illegal = 1'b1;
          end else if (op == OP_J) begin
            pcwr  = 1'b1;
            pcsrc = PC_JMP;
          end
        end
        S_EXE_R: ALUop = dec_aluop;
        S_WB_R: begin
          regdst = 1'b1;
          regwr  = 1'b1;
          ALUop  = dec_aluop;
        end
        S_EXE_I: begin
          ALUsrc = 1'b1;
          extop  = dec_extop;
          ALUop  = dec_aluop;
        end
        S_WB_I: begin
          ALUsrc = 1'b1;
          extop  = dec_extop;
          ALUop  = dec_aluop;
          regwr  = 1'b1;
        end
        S_EXE_MA: begin
          ALUsrc = 1'b1;
          extop  = 1'b1;
        end
        S_MEM_RD: memrd = 1'b1;
        S_WB_MEM: begin
          memtoreg = 1'b1;
          regwr    = 1'b1;
        end
        S_MEM_WR: memwr = 1'b1;
        S_EXE_BR: begin
          ALUop = ALU_SUB;
          extop = 1'b1;
          pcsrc = PC_BR;
          pcwr  = zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and
// control-vector checks against hand-computed constants.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       mem_rdy;
  logic       pcwr, irwr, memrd, memwr, regdst;
  logic       ALUsrc, memtoreg, regwr, extop, illegal;
  logic [1:0] pcsrc;
  logic [2:0] ALUop;
  logic [3:0] state;
  logic [14:0] ctl;

  int n_chk  = 0;
  int n_fail = 0;

  // {pcwr,pcsrc,irwr,memrd,memwr,regdst,ALUsrc,
  //  memtoreg,regwr,extop,ALUop,illegal}
  localparam logic [14:0] C_NONE  = 15'b0_00_0_0_0_0_0_0_0_0_000_0;
  localparam logic [14:0] C_IFGO  = 15'b1_00_1_1_0_0_0_0_0_0_000_0;
  localparam logic [14:0] C_IFW   = 15'b0_00_0_1_0_0_0_0_0_0_000_0;
  localparam logic [14:0] C_JMP   = 15'b1_10_0_0_0_0_0_0_0_0_000_0;
  localparam logic [14:0] C_ILL   = 15'b0_00_0_0_0_0_0_0_0_0_000_1;
  localparam logic [14:0] C_WBADD = 15'b0_00_0_0_0_1_0_0_1_0_000_0;
  localparam logic [14:0] C_EXSLT = 15'b0_00_0_0_0_0_0_0_0_0_100_0;
  localparam logic [14:0] C_WBSLT = 15'b0_00_0_0_0_1_0_0_1_0_100_0;
  localparam logic [14:0] C_EXMA  = 15'b0_00_0_0_0_0_1_0_0_1_000_0;
  localparam logic [14:0] C_MEMRD = 15'b0_00_0_1_0_0_0_0_0_0_000_0;
  localparam logic [14:0] C_WBMEM = 15'b0_00_0_0_0_0_0_1_1_0_000_0;
  localparam logic [14:0] C_MEMWR = 15'b0_00_0_0_1_0_0_0_0_0_000_0;
  localparam logic [14:0] C_BRT   = 15'b1_01_0_0_0_0_0_0_0_1_001_0;
  localparam logic [14:0] C_BRN   = 15'b0_01_0_0_0_0_0_0_0_1_001_0;
  localparam logic [14:0] C_EXORI = 15'b0_00_0_0_0_0_1_0_0_0_010_0;
  localparam logic [14:0] C_WBORI = 15'b0_00_0_0_0_0_1_0_1_0_010_0;

  multicycle_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op       (op),
    .func     (func),
    .zero     (zero),
    .mem_rdy  (mem_rdy),
    .pcwr     (pcwr),
    .pcsrc    (pcsrc),
    .irwr     (irwr),
    .memrd    (memrd),
    .memwr    (memwr),
    .regdst   (regdst),
    .ALUsrc   (ALUsrc),
    .memtoreg (memtoreg),
    .regwr    (regwr),
    .extop    (extop),
    .ALUop    (ALUop),
    .illegal  (illegal),
    .state    (state)
  );

  assign ctl = {pcwr, pcsrc, irwr, memrd, memwr, regdst,
                ALUsrc, memtoreg, regwr, extop, ALUop, illegal};

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // check one cycle (state + controls), then advance
  task automatic tick(input string tag,
                      input state_t es,
                      input logic [14:0] ec);
    #1;
    check({tag, "/st"}, 32'(state), 32'(es));
    check({tag, "/ctl"}, 32'(ctl), 32'(ec));
    @(posedge clk);
    #1;
  endtask

  task automatic release_rst;
    mem_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    op      = OP_RTYPE;
    func    = FN_ADDU;
    zero    = 1'b0;
    mem_rdy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst/ctl", 32'(ctl), 32'(C_NONE));
    check("rst/st", 32'(state), 32'(S_IF));
    release_rst();

    // reset asserted while decoding addu
    mem_rdy = 1'b1;
    tick("t1_if", S_IF, C_IFGO);
    check("t1_id", 32'(state), 32'(S_ID));
    rst_n = 1'b0;
    #1;
    check("t1_rst/ctl", 32'(ctl), 32'(C_NONE));
    check("t1_rst/st", 32'(state), 32'(S_IF));
    release_rst();
    tick("t1_rel", S_IF, C_IFW);

    // addu, 4 cycles
    mem_rdy = 1'b1;
    tick("t2_if", S_IF, C_IFGO);
    tick("t2_id", S_ID, C_NONE);
    tick("t2_ex", S_EXE_R, C_NONE);
    tick("t2_wb", S_WB_R, C_WBADD);

    // slt
    func = FN_SLT;
    tick("t2s_if", S_IF, C_IFGO);
    tick("t2s_id", S_ID, C_NONE);
    tick("t2s_ex", S_EXE_R, C_EXSLT);
    tick("t2s_wb", S_WB_R, C_WBSLT);

    // lw with three wait cycles in MEM_RD: 8 cycles
    op = OP_LW;
    tick("t3_if", S_IF, C_IFGO);
    tick("t3_id", S_ID, C_NONE);
    mem_rdy = 1'b0;
    tick("t3_ma", S_EXE_MA, C_EXMA);
    for (int i = 0; i < 3; i++)
      tick("t3_wait", S_MEM_RD, C_MEMRD);
    mem_rdy = 1'b1;
    tick("t3_rd", S_MEM_RD, C_MEMRD);
    tick("t3_wb", S_WB_MEM, C_WBMEM);

    // beq taken and not taken
    op   = OP_BEQ;
    zero = 1'b1;
    tick("t4t_if", S_IF, C_IFGO);
    tick("t4t_id", S_ID, C_NONE);
    tick("t4t_br", S_EXE_BR, C_BRT);
    zero = 1'b0;
    tick("t4n_if", S_IF, C_IFGO);
    tick("t4n_id", S_ID, C_NONE);
    tick("t4n_br", S_EXE_BR, C_BRN);

    // j in 2 cycles, then ori
    op = OP_J;
    tick("t5j_if", S_IF, C_IFGO);
    tick("t5j_id", S_ID, C_JMP);
    op = OP_ORI;
    tick("t5o_if", S_IF, C_IFGO);
    tick("t5o_id", S_ID, C_NONE);
    tick("t5o_ex", S_EXE_I, C_EXORI);
    tick("t5o_wb", S_WB_I, C_WBORI);

    // illegal opcode and illegal R-type func
    op = 6'b111111;
    tick("t6o_if", S_IF, C_IFGO);
    tick("t6o_id", S_ID, C_ILL);
    op   = OP_RTYPE;
    func = 6'b000000;
    tick("t6f_if", S_IF, C_IFGO);
    tick("t6f_id", S_ID, C_ILL);
    mem_rdy = 1'b0;
    tick("t6_back", S_IF, C_IFW);

    // sw, reset cuts the pending write
    op      = OP_SW;
    mem_rdy = 1'b1;
    tick("t7_if", S_IF, C_IFGO);
    tick("t7_id", S_ID, C_NONE);
    mem_rdy = 1'b0;
    tick("t7_ma", S_EXE_MA, C_EXMA);
    tick("t7_wr", S_MEM_WR, C_MEMWR);
    check("t7_hold", 32'(state), 32'(S_MEM_WR));
    rst_n = 1'b0;
    #1;
    check("t7_rst/ctl", 32'(ctl), 32'(C_NONE));
    check("t7_rst/st", 32'(state), 32'(S_IF));
    release_rst();
    tick("t7_rel", S_IF, C_IFW);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
